// File: rtl/iob_uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the arbiter and the uart_core transmitter.
// Signal names carry the arbiter's point of view (_i = into the arbiter, _o = out of it).
interface iob_uart_tx_arbiter_if #(
  parameter int N_REQ       = 4,
  parameter int UART_DATA_W = 8
);
  logic [N_REQ-1:0]             req_valid_i;
  logic [N_REQ*UART_DATA_W-1:0] req_data_i;
  logic [N_REQ-1:0]             req_last_i;
  logic [N_REQ-1:0]             req_ready_o;
  logic                         tx_ready_i;
  logic [UART_DATA_W-1:0]       tx_data_o;
  logic                         tx_wen_o;
  logic [N_REQ-1:0]             grant_o;
  logic                         busy_o;

  modport master (
    input  req_valid_i, req_data_i, req_last_i, tx_ready_i,
    output req_ready_o, tx_data_o, tx_wen_o, grant_o, busy_o
  );

  modport slave (
    output req_valid_i, req_data_i, req_last_i, tx_ready_i,
    input  req_ready_o, tx_data_o, tx_wen_o, grant_o, busy_o
  );
endinterface

// File: rtl/iob_uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte streams.
// A grant lasts a whole packet; an owner that goes quiet is dropped after HOLD_MAX cycles.
module iob_uart_tx_arbiter #(
  parameter int N_REQ       = 4,
  parameter int UART_DATA_W = 8,
  parameter int HOLD_MAX    = 255
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cke_i,
  input  logic                 rst_soft_i,
  iob_uart_tx_arbiter_if.master bus
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t                 r_state, w_state_nxt;
  logic [N_REQ-1:0]       r_grant, w_grant_nxt;
  logic [PTR_W-1:0]       r_ptr, w_ptr_nxt;
  logic                   r_last, w_last_nxt;
  logic [CNT_W-1:0]       r_cnt, w_cnt_nxt;
  logic [PTR_W-1:0]       w_pick, w_scan;
  logic                   w_pick_vld;
  logic                   w_fire;
  logic                   w_timeout;
  logic [UART_DATA_W-1:0] w_data [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      w_data[i] = bus.req_data_i[i*UART_DATA_W +: UART_DATA_W];
    end
  end

  // Scan downward so the nearest valid index after r_ptr is the last one written.
  always_comb begin
    w_pick_vld = 1'b0;
    w_pick     = r_ptr;
    w_scan     = r_ptr;
    for (int k = N_REQ; k >= 1; k--) begin
      w_scan = PTR_W'((int'(r_ptr) + k) % N_REQ);
      if (bus.req_valid_i[w_scan]) begin
        w_pick_vld = 1'b1;
        w_pick     = w_scan;
      end
    end
  end

  assign w_fire    = (r_state == S_SEND) && cke_i && !rst_soft_i &&
                     bus.tx_ready_i && bus.req_valid_i[r_ptr];
  assign w_timeout = (HOLD_MAX != 0) && (r_cnt == CNT_W'(HOLD_MAX - 1));

  // NOTE: every next-state signal gets its hold value first, so no branch can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_pick_vld) begin
          w_state_nxt = S_SEND;
          w_grant_nxt = N_REQ'(1) << w_pick;
          w_ptr_nxt   = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      S_SEND: begin
        if (w_fire) begin
          w_last_nxt  = bus.req_last_i[r_ptr];
          w_cnt_nxt   = '0;
          w_state_nxt = S_GAP;
        end else if (!bus.req_valid_i[r_ptr]) begin
          if (w_timeout) begin
            w_state_nxt = S_IDLE;
            w_grant_nxt = '0;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_last) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
        end else begin
          w_state_nxt = S_SEND;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all of them update from pre-edge values.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= PTR_W'(N_REQ - 1);
      r_last  <= 1'b0;
      r_cnt   <= '0;
    end else if (cke_i) begin
      if (rst_soft_i) begin
        r_state <= S_IDLE;
        r_grant <= '0;
        r_ptr   <= PTR_W'(N_REQ - 1);
        r_last  <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_state <= w_state_nxt;
        r_grant <= w_grant_nxt;
        r_ptr   <= w_ptr_nxt;
        r_last  <= w_last_nxt;
        r_cnt   <= w_cnt_nxt;
      end
    end
  end

  assign bus.tx_wen_o    = w_fire;
  assign bus.req_ready_o = w_fire ? r_grant : '0;
  assign bus.tx_data_o   = (|r_grant) ? w_data[r_ptr] : '0;
  assign bus.grant_o     = r_grant;
  assign bus.busy_o      = (r_state != S_IDLE);

endmodule
